serial_subtractor: RTL and testbench

//   Bit-serial, LSB-first subtractor: computes d = a - b - bin over WIDTH clock

---
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor: d = a - b - bin over WIDTH cycles with one full-subtractor cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic             br;
   logic             br_nxt;
   logic             dbit;
   logic [CW-1:0]    cnt;
   logic             last;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
`endif

   // Handshake: start is a request accepted only in IDLE; busy is high from the
   // cycle after acceptance through DONE, and done pulses once when d/bout update.
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   always_comb begin
      dbit    = sa[0] ^ sb[0] ^ br;
      br_nxt  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      res_nxt = WIDTH'({dbit, res} >> 1);
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa   <= '0;
         sb   <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         d    <= '0;
         bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
`endif
      end else if (state_q == IDLE) begin
         if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
         end
      end else if (state_q == RUN) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         br  <= br_nxt;
         res <= res_nxt;
         cnt <= cnt + CW'(1);
         // The final bit step writes straight into the held outputs.
         if (last) begin
            d    <= res_nxt;
            bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (a_msb != b_msb) && (dbit != a_msb);
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, busy/abort, random and
// shuffled-exhaustive operations checked against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 4;
   localparam int N = 1 << (2 * W + 1);

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_done   = 0;

   logic [W+1:0] exp_q[$];
   logic [W-1:0] held_d    = '0;
   logic         held_bout = 1'b0;
   logic [W+1:0] mon_e;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // reference model: {ovf, bout, d} from plain integer arithmetic
   function automatic logic [W+1:0] model(input int av, input int bv, input int binv);
      int           diff;
      logic [W-1:0] dm;
      logic [W-1:0] am;
      logic [W-1:0] bm;
      logic         borrow;
      logic         om;
      diff   = av - bv - binv;
      dm     = W'(diff);
      borrow = (diff < 0);
      am     = W'(av);
      bm     = W'(bv);
      om     = (am[W-1] != bm[W-1]) && (dm[W-1] != am[W-1]);
      return {om, borrow, dm};
   endfunction

   // scoreboard: every done pops one expected result
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("d", d, mon_e[W-1:0]);
            check("bout", bout, mon_e[W]);
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", ovf, mon_e[W+1]);
`endif
            held_d    = mon_e[W-1:0];
            held_bout = mon_e[W];
         end
      end
   end

   // driver tasks (all entered and left on a negedge)
   task automatic do_reset(input int ncyc);
      rst_n = 1'b0;
      start = 1'b0;
      repeat (ncyc) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      held_d    = '0;
      held_bout = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int cyc;
      cyc = 0;
      while (busy !== 1'b0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      ok = (busy === 1'b0);
      if (!ok) check("idle_timeout", busy, 0);
   endtask

   task automatic run_op(input int av, input int bv, input int binv, input bit poke);
      int cyc;
      bit got;
      bit ok;
      wait_idle(ok);
      if (!ok) return;
      a     = W'(av);
      b     = W'(bv);
      bin   = 1'(binv);
      start = 1'b1;
      exp_q.push_back(model(av, bv, binv));
      cyc = 0;
      got = 0;
      while (cyc < 3 * W && !got) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            check("busy_after_start", busy, 1);
         end
         if (done === 1'b1) begin
            got = 1;
         end else begin
            check("hold_d", d, held_d);
            check("hold_bout", bout, held_bout);
            if (poke && cyc >= 2) begin
               start = 1'b1;
               a     = W'(1);
               b     = W'(1);
               bin   = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("latency", cyc, W + 1);
   endtask

   task automatic run_abort();
      bit ok;
      bit saw;
      wait_idle(ok);
      if (!ok) return;
      a     = W'(9);
      b     = W'(3);
      bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      held_d    = '0;
      held_bout = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_d", d, 0);
      check("abort_bout", bout, 0);
      saw = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (done === 1'b1) saw = 1;
      end
      check("abort_no_done", saw, 0);
   endtask

   int perm[N];

   initial begin
      int d0;
      int av, bv, binv, v;
      int mask;
      mask  = (1 << W) - 1;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      @(negedge clk);

      do_reset(2);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_d", d, 0);
      check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", ovf, 0);
`endif

      run_op(9, 3, 0, 0);
      check("t2_d", d, 6);
      check("t2_bout", bout, 0);
      run_op(3, 9, 0, 0);
      check("t3a_d", d, 10);
      check("t3a_bout", bout, 1);
      run_op(0, 0, 1, 0);
      check("t3b_d", d, 15);
      check("t3b_bout", bout, 1);
      run_op(15, 15, 1, 0);
      check("t3c_d", d, 15);
      check("t3c_bout", bout, 1);

      run_op(9, 3, 0, 1);
      check("t4_ignored_d", d, 6);
      run_abort();

`ifdef SERIAL_SUB_OVF_EN
      run_op(8, 1, 0, 0);
      check("t6a_d", d, 7);
      check("t6a_ovf", ovf, 1);
      run_op(7, 15, 0, 0);
      check("t6b_d", d, 8);
      check("t6b_ovf", ovf, 1);
      run_op(5, 2, 0, 0);
      check("t6c_d", d, 3);
      check("t6c_ovf", ovf, 0);
`endif

      repeat (40) begin
         run_op($urandom_range(mask, 0), $urandom_range(mask, 0),
                $urandom_range(1, 0), 1'($urandom));
      end

      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         int j;
         int t;
         j       = $urandom_range(i, 0);
         t       = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      d0 = n_done;
      for (int k = 0; k < N; k++) begin
         v    = perm[k];
         av   = (v >> (W + 1)) & mask;
         bv   = (v >> 1) & mask;
         binv = v & 1;
         run_op(av, bv, binv, 0);
      end
      check("exh_done_count", n_done - d0, N);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
